// File: rtl/vip_dehaze_recover_pkg.sv
// rtl/vip_dehaze_recover_pkg.sv - shared constants, FSM encoding and recovery helper for the dehaze recover stage
package vip_dehaze_recover_pkg;

    localparam logic [9:0] IMG_HDISP = 10'd800;
    localparam logic [9:0] IMG_VDISP = 10'd600;

    localparam int Q8_ONE  = 256;
    localparam int RECIP_W = 16;
    localparam int RINV_W  = 17;

    localparam logic [8:0]         OMEGA_Q8_DEF = 9'd243;
    localparam logic [8:0]         T0_Q8_DEF    = 9'd26;
    localparam logic [7:0]         A_RST        = 8'd255;
    localparam logic [RECIP_W-1:0] RECIP_RST    = 16'd257;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_COMMIT
    } coef_state_t;

    // J = floor(d*rinv / 256) + A, saturated to a pixel
    function automatic logic [7:0] recover(input logic signed [8:0] d,
                                           input logic [RINV_W-1:0] rinv,
                                           input logic [7:0] a);
        logic signed [26:0] prod;
        logic signed [19:0] j;
        prod = d * $signed({1'b0, rinv});
        j    = 20'(prod >>> 8) + $signed({12'b0, a});
        if (j < 0)
            return 8'd0;
        else if (j > 20'sd255)
            return 8'd255;
        else
            return j[7:0];
    endfunction

endpackage

// File: rtl/vip_recip_rom.sv
// rtl/vip_recip_rom.sv - registered reciprocal table, data = floor(65536/t)
module vip_recip_rom
    import vip_dehaze_recover_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [8:0]        addr,
    output logic [RINV_W-1:0] data
);

    logic [RINV_W-1:0] table_w [512];

    // Constant divisions fold to a lookup table; t=0 never reaches the address
    for (genvar i = 0; i < 512; i++) begin : g_rom
        if (i == 0) begin : g_zero
            assign table_w[i] = '0;
        end else begin : g_val
            assign table_w[i] = RINV_W'(65536 / i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            data <= '0;
        else
            data <= table_w[addr];
    end

endmodule

// File: rtl/vip_dehaze_recover.sv
// rtl/vip_dehaze_recover.sv - transmission estimate and scene radiance recovery with per-frame 1/A divider
module vip_dehaze_recover
    import vip_dehaze_recover_pkg::*;
#(
    parameter logic [8:0] OMEGA_Q8 = OMEGA_Q8_DEF,
    parameter logic [8:0] T0_Q8    = T0_Q8_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Dark,
    input  logic [7:0] per_img_red,
    input  logic [7:0] per_img_green,
    input  logic [7:0] per_img_blue,
    input  logic [7:0] atmospheric_light,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);

    coef_state_t        state;
    logic               vsync_d;
    logic [7:0]         a_new;
    logic [7:0]         a_act;
    logic [RECIP_W-1:0] recip_act;
    logic               bypass_nxt;
    logic               bypass_act;
    logic [7:0]         rem;
    logic [15:0]        quo;
    logic [3:0]         div_cnt;
    logic [8:0]         rem_sh;
    logic               div_ge;

    assign rem_sh = {rem, quo[15]};
    assign div_ge = rem_sh >= {1'b0, a_new};

    // Dividend starts as all ones in quo; each step shifts one dividend bit into rem
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vsync_d    <= 1'b0;
            a_new      <= '0;
            a_act      <= A_RST;
            recip_act  <= RECIP_RST;
            bypass_nxt <= 1'b0;
            bypass_act <= 1'b0;
            rem        <= '0;
            quo        <= '0;
            div_cnt    <= '0;
        end else begin
            vsync_d <= per_frame_vsync;
            case (state)
                ST_IDLE: begin
                    if (per_frame_vsync && !vsync_d)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!per_frame_vsync) begin
                        state <= ST_IDLE;
                    end else begin
                        a_new      <= atmospheric_light;
                        bypass_nxt <= (atmospheric_light == 8'd0);
                        rem        <= '0;
                        quo        <= 16'hFFFF;
                        div_cnt    <= '0;
                        state      <= (atmospheric_light == 8'd0) ? ST_COMMIT : ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (!per_frame_vsync) begin
                        state <= ST_IDLE;
                    end else begin
                        rem     <= div_ge ? 8'(rem_sh - {1'b0, a_new}) : rem_sh[7:0];
                        quo     <= {quo[14:0], div_ge};
                        div_cnt <= div_cnt + 4'd1;
                        if (div_cnt == 4'd15)
                            state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (per_frame_vsync) begin
                        a_act      <= a_new;
                        recip_act  <= quo;
                        bypass_act <= bypass_nxt;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [15:0]       dq;
    logic [8:0]        w;
    logic [8:0]        t_raw;
    logic [8:0]        q1;
    logic [8:0]        t2;
    logic [23:0]       rgb1, rgb2, rgb3;
    logic signed [8:0] d_r3, d_g3, d_b3;
    logic [RINV_W-1:0] rinv3;
    logic [3:0]        vs_sr, hr_sr, ck_sr;

    assign dq    = 16'((24'(per_img_Dark) * 24'(recip_act)) >> 8);
    assign w     = 9'((18'(OMEGA_Q8) * 18'(q1)) >> 8);
    assign t_raw = 9'(Q8_ONE) - w;

    vip_recip_rom u_recip_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (t2),
        .data (rinv3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q1     <= '0;
            t2     <= '0;
            rgb1   <= '0;
            rgb2   <= '0;
            rgb3   <= '0;
            d_r3   <= '0;
            d_g3   <= '0;
            d_b3   <= '0;
            vs_sr  <= '0;
            hr_sr  <= '0;
            ck_sr  <= '0;
            post_img_red   <= '0;
            post_img_green <= '0;
            post_img_blue  <= '0;
        end else begin
            q1   <= (dq > 16'd256) ? 9'd256 : dq[8:0];
            rgb1 <= {per_img_red, per_img_green, per_img_blue};
            t2   <= (t_raw < T0_Q8) ? T0_Q8 : t_raw;
            rgb2 <= rgb1;
            rgb3 <= rgb2;
            d_r3 <= $signed({1'b0, rgb2[23:16]}) - $signed({1'b0, a_act});
            d_g3 <= $signed({1'b0, rgb2[15:8]})  - $signed({1'b0, a_act});
            d_b3 <= $signed({1'b0, rgb2[7:0]})   - $signed({1'b0, a_act});
            vs_sr <= {vs_sr[2:0], per_frame_vsync};
            hr_sr <= {hr_sr[2:0], per_frame_href};
            ck_sr <= {ck_sr[2:0], per_frame_clken};
            // A=0 has no defined recovery, so the frame passes through untouched
            if (bypass_act) begin
                post_img_red   <= rgb3[23:16];
                post_img_green <= rgb3[15:8];
                post_img_blue  <= rgb3[7:0];
            end else begin
                post_img_red   <= recover(d_r3, rinv3, a_act);
                post_img_green <= recover(d_g3, rinv3, a_act);
                post_img_blue  <= recover(d_b3, rinv3, a_act);
            end
        end
    end

    assign post_frame_vsync = vs_sr[3];
    assign post_frame_href  = hr_sr[3];
    assign post_frame_clken = ck_sr[3];

endmodule

// File: tb/tb_vip_dehaze_recover.sv
// tb/tb_vip_dehaze_recover.sv - table-driven scoreboard bench for vip_dehaze_recover
module tb_vip_dehaze_recover;

    logic       clk = 1'b0;
    logic       rst;
    logic       per_frame_vsync, per_frame_href, per_frame_clken;
    logic [7:0] per_img_Dark, per_img_red, per_img_green, per_img_blue;
    logic [7:0] atmospheric_light;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0] post_img_red, post_img_green, post_img_blue;

    vip_dehaze_recover dut (
        .clk               (clk),
        .rst               (rst),
        .per_frame_vsync   (per_frame_vsync),
        .per_frame_href    (per_frame_href),
        .per_frame_clken   (per_frame_clken),
        .per_img_Dark      (per_img_Dark),
        .per_img_red       (per_img_red),
        .per_img_green     (per_img_green),
        .per_img_blue      (per_img_blue),
        .atmospheric_light (atmospheric_light),
        .post_frame_vsync  (post_frame_vsync),
        .post_frame_href   (post_frame_href),
        .post_frame_clken  (post_frame_clken),
        .post_img_red      (post_img_red),
        .post_img_green    (post_img_green),
        .post_img_blue     (post_img_blue)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] rgb;
        int          due;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  dark;
        logic [23:0] rgb;
        logic [23:0] exp;
    } vec_t;

    exp_t sb[$];
    exp_t got_e;
    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && post_frame_clken === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pixel: got rgb 0x%0h with empty scoreboard at cycle %0d",
                         {post_img_red, post_img_green, post_img_blue}, cyc);
            end else begin
                got_e = sb.pop_front();
                check("pixel_rgb", {8'd0, post_img_red, post_img_green, post_img_blue}, {8'd0, got_e.rgb});
                check("pixel_latency", cyc, got_e.due);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            per_frame_href  = 1'b0;
            per_frame_clken = 1'b0;
        end
    endtask

    task automatic vsync_pulse(input logic [7:0] a, input int len);
        @(negedge clk);
        per_frame_vsync   = 1'b1;
        atmospheric_light = a;
        repeat (len) @(negedge clk);
        per_frame_vsync = 1'b0;
        idle(4);
    endtask

    task automatic pixel(input logic [7:0] dark, input logic [23:0] rgb, input logic [23:0] exp);
        @(negedge clk);
        per_frame_href  = 1'b1;
        per_frame_clken = 1'b1;
        per_img_Dark    = dark;
        {per_img_red, per_img_green, per_img_blue} = rgb;
        sb.push_back('{rgb: exp, due: cyc + 4});
        @(negedge clk);
        per_frame_clken = 1'b0;
        per_img_Dark    = 8'hA5;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d pixels still pending, required 0", sb.size());
            sb.delete();
        end
        idle(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a: 8'd77,  dark: 8'd0,   rgb: {8'd150, 8'd100, 8'd50},  exp: {8'd150, 8'd100, 8'd50}};
        vecs[1] = '{a: 8'd77,  dark: 8'd0,   rgb: {8'd0,   8'd255, 8'd7},   exp: {8'd0,   8'd255, 8'd7}};
        vecs[2] = '{a: 8'd200, dark: 8'd100, rgb: {8'd150, 8'd100, 8'd50},  exp: {8'd106, 8'd12,  8'd0}};
        vecs[3] = '{a: 8'd200, dark: 8'd200, rgb: {8'd200, 8'd200, 8'd200}, exp: {8'd200, 8'd200, 8'd200}};
        vecs[4] = '{a: 8'd200, dark: 8'd0,   rgb: {8'd10,  8'd20,  8'd30},  exp: {8'd10,  8'd20,  8'd30}};
        vecs[5] = '{a: 8'd200, dark: 8'd50,  rgb: {8'd250, 8'd0,   8'd128}, exp: {8'd255, 8'd0,   8'd106}};
        vecs[6] = '{a: 8'd50,  dark: 8'd50,  rgb: {8'd255, 8'd255, 8'd255}, exp: {8'd255, 8'd255, 8'd255}};
        vecs[7] = '{a: 8'd0,   dark: 8'd100, rgb: {8'd150, 8'd100, 8'd50},  exp: {8'd150, 8'd100, 8'd50}};
        vecs[8] = '{a: 8'd0,   dark: 8'd200, rgb: {8'd1,   8'd2,   8'd3},   exp: {8'd1,   8'd2,   8'd3}};
        vecs[9] = '{a: 8'd200, dark: 8'd100, rgb: {8'd150, 8'd100, 8'd50},  exp: {8'd106, 8'd12,  8'd0}};

        rst               = 1'b1;
        per_frame_vsync   = 1'b0;
        per_frame_href    = 1'b0;
        per_frame_clken   = 1'b0;
        per_img_Dark      = 8'd0;
        per_img_red       = 8'd0;
        per_img_green     = 8'd0;
        per_img_blue      = 8'd0;
        atmospheric_light = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_outputs", {8'd0, post_frame_vsync, post_frame_href, post_frame_clken, 5'd0,
                                post_img_red, post_img_green}, 32'd0);
        check("reset_blue", {24'd0, post_img_blue}, 32'd0);
        check("reset_coef", {8'd0, dut.a_act, dut.recip_act}, {8'd0, 8'd255, 16'd257});

        for (int i = 0; i < 10; i++) begin
            if (i == 0 || vecs[i].a != vecs[i-1].a) begin
                drain();
                vsync_pulse(vecs[i].a, 24);
            end
            pixel(vecs[i].dark, vecs[i].rgb, vecs[i].exp);
        end
        drain();

        // Short blanking: divide must abort and leave A=200 in force
        vsync_pulse(8'd100, 10);
        check("abort_keeps_a", {24'd0, dut.a_act}, 32'd200);
        pixel(8'd100, {8'd150, 8'd100, 8'd50}, {8'd106, 8'd12, 8'd0});
        drain();

        // Reset in the middle of a divide restores the reset coefficients
        @(negedge clk);
        per_frame_vsync   = 1'b1;
        atmospheric_light = 8'd100;
        repeat (8) @(negedge clk);
        rst             = 1'b1;
        per_frame_vsync = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_mid_div_coef", {8'd0, dut.a_act, dut.recip_act}, {8'd0, 8'd255, 16'd257});
        idle(2);
        pixel(8'd100, {8'd150, 8'd100, 8'd50}, {8'd89, 8'd10, 8'd0});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
